// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM side of ram_arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters/RAM.
interface ram_arbiter_if #(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned DW     = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [DW-1:0]     m0_wdata;
  logic [3:0]        m0_wstrb;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DW-1:0]     m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [DW-1:0]     m1_wdata;
  logic [3:0]        m1_wstrb;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DW-1:0]     m1_rdata;
  logic              m1_err;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single-port data RAM, 1-cycle read response.
// Optional simulation halt snoop enabled by defining SIM_HALT_DETECT_EN.
module ram_arbiter #(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned DW     = 32
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus,
  output logic         halt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic          rsp_read, rsp_read_nxt;
  logic          rsp_err, rsp_err_nxt;
  logic          rsp_vld;

  logic          gnt0, gnt1, any_gnt;
  logic          sel_we, in_range;
  logic [31:2]   sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [3:0]    sel_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      rsp_read <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      rsp_read <= rsp_read_nxt;
      rsp_err  <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = IDLE;
    prio_nxt     = prio;
    rsp_read_nxt = rsp_read;
    rsp_err_nxt  = rsp_err;

    gnt0    = !rst && bus.m0_req && (!bus.m1_req || !prio);
    gnt1    = !rst && bus.m1_req && (!bus.m0_req ||  prio);
    any_gnt = gnt0 || gnt1;

    sel_we    = gnt1 ? bus.m1_we          : bus.m0_we;
    sel_addr  = gnt1 ? bus.m1_addr[31:2]  : bus.m0_addr[31:2];
    sel_wdata = gnt1 ? bus.m1_wdata       : bus.m0_wdata;
    sel_wstrb = gnt1 ? bus.m1_wstrb       : bus.m0_wstrb;
    in_range  = (sel_addr[31:RAM_AW+2] == '0);

    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.ram_en    = any_gnt && in_range;
    bus.ram_we    = (any_gnt && in_range && sel_we) ? sel_wstrb : '0;
    bus.ram_addr  = any_gnt ? sel_addr[RAM_AW+1:2] : '0;
    bus.ram_wdata = any_gnt ? sel_wdata : '0;

    if (any_gnt) begin
      state_nxt    = gnt1 ? GNT1 : GNT0;
      prio_nxt     = gnt0;
      rsp_read_nxt = !sel_we;
      rsp_err_nxt  = !in_range;
    end

    // In-range writes complete silently; gating by rst drops a response caught by reset.
    rsp_vld       = !rst && (rsp_read || rsp_err);
    bus.m0_rvalid = rsp_vld && (state == GNT0);
    bus.m1_rvalid = rsp_vld && (state == GNT1);
    bus.m0_err    = bus.m0_rvalid && rsp_err;
    bus.m1_err    = bus.m1_rvalid && rsp_err;
    bus.m0_rdata  = (bus.m0_rvalid && !rsp_err) ? bus.ram_rdata : '0;
    bus.m1_rdata  = (bus.m1_rvalid && !rsp_err) ? bus.ram_rdata : '0;
  end

`ifdef SIM_HALT_DETECT_EN
  logic halt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (bus.ram_en && sel_we && (sel_addr == 30'd4) &&
                 (sel_wstrb == 4'hF) && (sel_wdata == DW'(1))) begin
      halt_q <= 1'b1;
    end
  end

  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic halt;
  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef SIM_HALT_DETECT_EN
  localparam logic HALT_EXP = 1'b1;
`else
  localparam logic HALT_EXP = 1'b0;
`endif

  logic [31:0] mem [0:1023];
  logic [31:0] rdata_q;

  ram_arbiter_if #(.RAM_AW(10), .DW(32)) bus ();

  ram_arbiter #(.RAM_AW(10), .DW(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .halt (halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      if (bus.ram_we == 4'h0) rdata_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = rdata_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
    bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
    bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
  endtask

  task automatic idle_both();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic m0_write_then_check_halt(input logic [31:0] wdata, input logic [3:0] wstrb,
                                          input logic exp_halt, input string tag);
    set_m0(1'b1, 1'b1, 32'h10, wdata, wstrb);
    next_cycle();
    idle_both();
    #1;
    check(tag, halt, exp_halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5]  = 32'hDEADBEEF;
    mem[8]  = 32'hAAAAAAAA;
    rdata_q = 32'h0;
    rst = 1'b1;
    idle_both();

    // Reset: combinational outputs forced low even with requests present
    repeat (2) @(posedge clk);
    #1;
    set_m0(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("rst_m0_gnt", bus.m0_gnt, 1'b0);
    check("rst_m1_gnt", bus.m1_gnt, 1'b0);
    check("rst_ram_en", bus.ram_en, 1'b0);
    check("rst_ram_we", bus.ram_we, 4'h0);
    check("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("rst_halt", halt, 1'b0);
    idle_both();
    next_cycle();
    rst = 1'b0;
    #1;
    check("post_rst_m0_rvalid", bus.m0_rvalid, 1'b0);

    // Single-port read of word 5
    set_m0(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    #1;
    check("rd_m0_gnt", bus.m0_gnt, 1'b1);
    check("rd_m1_gnt", bus.m1_gnt, 1'b0);
    check("rd_ram_en", bus.ram_en, 1'b1);
    check("rd_ram_addr", bus.ram_addr, 10'd5);
    check("rd_ram_we", bus.ram_we, 4'h0);
    next_cycle();
    idle_both();
    #1;
    check("rd_m0_rvalid", bus.m0_rvalid, 1'b1);
    check("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("rd_m0_err", bus.m0_err, 1'b0);
    check("rd_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("rd_m1_rdata", bus.m1_rdata, 32'h0);

    // Reset pulse so contention starts with m0 favoured (prio was 1 after the read)
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Contention: alternating grants, each rvalid one cycle after its own grant
    set_m0(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_m0_gnt", bus.m0_gnt, (k % 2) == 0);
      check("cont_m1_gnt", bus.m1_gnt, (k % 2) == 1);
      if (k > 0) begin
        check("cont_m0_rvalid", bus.m0_rvalid, (k % 2) == 1);
        check("cont_m1_rvalid", bus.m1_rvalid, (k % 2) == 0);
        check("cont_m0_rdata", bus.m0_rdata, ((k % 2) == 1) ? 32'hDEADBEEF : 32'h0);
        check("cont_m1_rdata", bus.m1_rdata, ((k % 2) == 0) ? 32'hAAAAAAAA : 32'h0);
      end
      next_cycle();
    end
    idle_both();
    #1;
    check("cont_last_m1_rvalid", bus.m1_rvalid, 1'b1);
    check("cont_last_m1_rdata", bus.m1_rdata, 32'hAAAAAAAA);
    check("cont_last_m0_rvalid", bus.m0_rvalid, 1'b0);

    // Byte write from m1, low half only
    set_m1(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0011);
    #1;
    check("bw_m1_gnt", bus.m1_gnt, 1'b1);
    check("bw_ram_we", bus.ram_we, 4'b0011);
    check("bw_ram_addr", bus.ram_addr, 10'd8);
    check("bw_ram_wdata", bus.ram_wdata, 32'h11223344);
    next_cycle();
    idle_both();
    #1;
    check("bw_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("bw_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("bw_mem8", mem[8], 32'hAAAA3344);

    // Last in-range word
    set_m0(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
    #1;
    check("edge_ram_en", bus.ram_en, 1'b1);
    check("edge_ram_addr", bus.ram_addr, 10'd1023);
    next_cycle();
    idle_both();
    #1;
    check("edge_m0_err", bus.m0_err, 1'b0);

    // Out of range read
    set_m0(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    #1;
    check("oor_m0_gnt", bus.m0_gnt, 1'b1);
    check("oor_ram_en", bus.ram_en, 1'b0);
    next_cycle();
    idle_both();
    #1;
    check("oor_m0_rvalid", bus.m0_rvalid, 1'b1);
    check("oor_m0_err", bus.m0_err, 1'b1);
    check("oor_m0_rdata", bus.m0_rdata, 32'h0);

    // Out of range write: error response, no RAM write
    set_m1(1'b1, 1'b1, 32'h1000, 32'h55555555, 4'hF);
    #1;
    check("oorw_m1_gnt", bus.m1_gnt, 1'b1);
    check("oorw_ram_en", bus.ram_en, 1'b0);
    check("oorw_ram_we", bus.ram_we, 4'h0);
    next_cycle();
    idle_both();
    #1;
    check("oorw_m1_rvalid", bus.m1_rvalid, 1'b1);
    check("oorw_m1_err", bus.m1_err, 1'b1);
    check("oorw_mem0", mem[0], 32'h0);

    // Reset while an m1 read response is pending
    set_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("rmid_m1_gnt", bus.m1_gnt, 1'b1);
    next_cycle();
    idle_both();
    rst = 1'b1;
    #1;
    check("rmid_m1_rvalid_in_rst", bus.m1_rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rmid_m1_rvalid_after", bus.m1_rvalid, 1'b0);
    set_m0(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("rmid_prio_m0_gnt", bus.m0_gnt, 1'b1);
    check("rmid_prio_m1_gnt", bus.m1_gnt, 1'b0);
    next_cycle();
    idle_both();
    #1;

    // Halt snoop: only full-word write of 1 to byte 0x10 sets it, and it sticks
    m0_write_then_check_halt(32'h2, 4'hF, 1'b0, "halt_wrong_data");
    m0_write_then_check_halt(32'h1, 4'h1, 1'b0, "halt_wrong_strb");
    m0_write_then_check_halt(32'h1, 4'hF, HALT_EXP, "halt_set");
    next_cycle();
    #1;
    check("halt_sticky", halt, HALT_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
